// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scanner for N-digit 7-segment displays.
// Owns its scan counter and prescaler. It snapshots the digit bus once per
// frame, so a digit never changes part-way through a frame. It also provides
// freeze (hold/lap), leading-zero blanking and a frame-start strobe.
module display_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic                          freeze,
    input  logic                          lzb_en,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [DIGIT_W-1:0]            digit_val,
    output logic                          blank,
    output logic                          frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = NUM_DIGITS * DIGIT_W;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // A slot above digit 0 is blank when it and every more-significant digit are zero.
    function automatic logic slot_blanked(input logic [BW-1:0] snap,
                                          input logic [IW-1:0] idx,
                                          input logic          lzb);
        logic hi_zero;
        hi_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx)) && (snap[i*DIGIT_W +: DIGIT_W] != {DIGIT_W{1'b0}})) begin
                hi_zero = 1'b0;
            end else begin
                hi_zero = hi_zero;
            end
        end
        if (lzb && (idx != {IW{1'b0}})) begin
            return hi_zero;
        end else begin
            return 1'b0;
        end
    endfunction

    logic [PW-1:0]         pre_cnt_r;
    logic [IW-1:0]         idx_r;
    logic [BW-1:0]         snap_r;
    logic                  lzb_r;
    logic [NUM_DIGITS-1:0] digit_sel_r;
    logic [DIGIT_W-1:0]    digit_val_r;
    logic                  blank_r;
    logic                  frame_start_r;

    logic                  tick_s;
    logic                  frame_tick_s;
    logic [PW-1:0]         pre_nxt_s;
    logic [IW-1:0]         idx_nxt_s;
    logic [BW-1:0]         snap_nxt_s;
    logic                  lzb_nxt_s;
    logic                  blank_nxt_s;
    logic [NUM_DIGITS-1:0] sel_nxt_s;
    logic [DIGIT_W-1:0]    val_nxt_s;

    // Next-state for the prescaler, scan index and per-frame snapshot, plus the output decode.
    always_comb begin
        tick_s       = (pre_cnt_r == PRE_LAST);
        frame_tick_s = tick_s && (idx_r == IDX_LAST);
        pre_nxt_s    = pre_cnt_r;
        idx_nxt_s    = idx_r;
        snap_nxt_s   = snap_r;
        lzb_nxt_s    = lzb_r;

        if (tick_s) begin
            pre_nxt_s = {PW{1'b0}};
        end else begin
            pre_nxt_s = pre_cnt_r + PW'(1);
        end

        if (tick_s) begin
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IW{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IW'(1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end

        // freeze and lzb_en only matter at the frame boundary
        if (frame_tick_s) begin
            lzb_nxt_s = lzb_en;
            if (!freeze) begin
                snap_nxt_s = digits_in;
            end else begin
                snap_nxt_s = snap_r;
            end
        end else begin
            lzb_nxt_s  = lzb_r;
            snap_nxt_s = snap_r;
        end

        blank_nxt_s = slot_blanked(snap_nxt_s, idx_nxt_s, lzb_nxt_s);
        if (blank_nxt_s) begin
            sel_nxt_s = {NUM_DIGITS{1'b0}};
            val_nxt_s = {DIGIT_W{1'b0}};
        end else begin
            sel_nxt_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt_s;
            val_nxt_s = snap_nxt_s[idx_nxt_s*DIGIT_W +: DIGIT_W];
        end
    end

    // State and registered outputs; the outputs only move on a tick and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r     <= {PW{1'b0}};
            idx_r         <= IDX_LAST;
            snap_r        <= {BW{1'b0}};
            lzb_r         <= 1'b0;
            digit_sel_r   <= {NUM_DIGITS{1'b0}};
            digit_val_r   <= {DIGIT_W{1'b0}};
            blank_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            pre_cnt_r     <= pre_nxt_s;
            idx_r         <= idx_nxt_s;
            snap_r        <= snap_nxt_s;
            lzb_r         <= lzb_nxt_s;
            frame_start_r <= frame_tick_s;
            if (tick_s) begin
                digit_sel_r <= sel_nxt_s;
                digit_val_r <= val_nxt_s;
                blank_r     <= blank_nxt_s;
            end else begin
                digit_sel_r <= digit_sel_r;
                digit_val_r <= digit_val_r;
                blank_r     <= blank_r;
            end
        end
    end

    assign digit_sel   = digit_sel_r;
    assign digit_val   = digit_val_r;
    assign blank       = blank_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: a PRESCALE=4 instance driven from a
// frame table, plus a PRESCALE=1 instance sharing the same inputs.
module tb_display_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        freeze;
    logic        lzb_en;

    logic [3:0]  sel4, sel1;
    logic [3:0]  val4, val1;
    logic        blk4, blk1;
    logic        fs4, fs1;

    int total = 0;
    int bad   = 0;

    display_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .PRESCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .freeze(freeze), .lzb_en(lzb_en),
        .digit_sel(sel4), .digit_val(val4), .blank(blk4), .frame_start(fs4)
    );

    display_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .PRESCALE(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .freeze(freeze), .lzb_en(lzb_en),
        .digit_sel(sel1), .digit_val(val1), .blank(blk1), .frame_start(fs1)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One frame: inputs presented during the previous frame, expected display per slot.
    typedef struct {
        logic [15:0] din;
        logic        fz;
        logic        lzb;
        logic [15:0] sel;   // slot s expected digit_sel at [s*4 +: 4]
        logic [15:0] val;   // slot s expected digit_val at [s*4 +: 4]
        logic [3:0]  blk;   // slot s expected blank at [s]
    } frame_t;

    frame_t vec[9];

    task automatic chk(input string name,
                       input logic [3:0] gs, input logic [3:0] gv, input logic gb, input logic gf,
                       input logic [3:0] es, input logic [3:0] ev, input logic eb, input logic ef);
        total++;
        if (gs !== es || gv !== ev || gb !== eb || gf !== ef) begin
            bad++;
            $display("FAIL %s @%0t: got sel=%b val=%h blank=%b fs=%b, want sel=%b val=%h blank=%b fs=%b",
                     name, $time, gs, gv, gb, gf, es, ev, eb, ef);
        end
    endtask

    initial begin
        logic [15:0] d;
        int slot;

        vec[0] = '{16'h1234, 1'b0, 1'b0, 16'h8421, 16'h1234, 4'b0000};
        vec[1] = '{16'h5678, 1'b0, 1'b0, 16'h8421, 16'h5678, 4'b0000};
        vec[2] = '{16'h9999, 1'b1, 1'b0, 16'h8421, 16'h5678, 4'b0000};
        vec[3] = '{16'h9999, 1'b0, 1'b0, 16'h8421, 16'h9999, 4'b0000};
        vec[4] = '{16'h0050, 1'b0, 1'b1, 16'h0021, 16'h0050, 4'b1100};
        vec[5] = '{16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0000, 4'b1110};
        vec[6] = '{16'h0000, 1'b0, 1'b0, 16'h8421, 16'h0000, 4'b0000};
        vec[7] = '{16'h0A0B, 1'b0, 1'b1, 16'h0421, 16'h0A0B, 4'b1000};
        vec[8] = '{16'h1234, 1'b1, 1'b1, 16'h0421, 16'h0A0B, 4'b1000};

        rst_n     = 1'b0;
        digits_in = vec[0].din;
        freeze    = vec[0].fz;
        lzb_en    = vec[0].lzb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_p4", sel4, val4, blk4, fs4, 4'b0000, 4'h0, 1'b0, 1'b0);
        chk("reset_p1", sel1, val1, blk1, fs1, 4'b0000, 4'h0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            chk("pre_first_frame", sel4, val4, blk4, fs4, 4'b0000, 4'h0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;

        // Each frame: queue the next row's inputs right after the frame starts, then check 16 cycles.
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                digits_in = vec[k+1].din;
                freeze    = vec[k+1].fz;
                lzb_en    = vec[k+1].lzb;
            end
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    chk($sformatf("frame%0d_slot%0d_cyc%0d", k, s, c), sel4, val4, blk4, fs4,
                        vec[k].sel[s*4 +: 4], vec[k].val[s*4 +: 4], vec[k].blk[s],
                        (s == 0 && c == 0));
                    @(posedge clk);
                    #1;
                end
            end
        end

        // Asynchronous reset mid-frame.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_p4", sel4, val4, blk4, fs4, 4'b0000, 4'h0, 1'b0, 1'b0);
        chk("async_reset_p1", sel1, val1, blk1, fs1, 4'b0000, 4'h0, 1'b0, 1'b0);
        digits_in = 16'h1234;
        freeze    = 1'b0;
        lzb_en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d = 16'h1234;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (e < 4) begin
                chk("restart_wait", sel4, val4, blk4, fs4, 4'b0000, 4'h0, 1'b0, 1'b0);
            end else if (e < 8) begin
                chk("restart_digit0", sel4, val4, blk4, fs4, 4'b0001, 4'h4, 1'b0, (e == 4));
            end else begin
                chk("restart_digit1", sel4, val4, blk4, fs4, 4'b0010, 4'h3, 1'b0, 1'b0);
            end
            slot = (e - 1) % 4;
            chk($sformatf("fast_edge%0d", e), sel1, val1, blk1, fs1,
                4'(1 << slot), d[slot*4 +: 4], 1'b0, (slot == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
